// File: rtl/scene_renderer_if.sv
// Bundle between the scene renderer and its surroundings: latched game state
// in, sprite ROM port, and the pixel stream to the colour decoder.
interface scene_renderer_if #(
    parameter int N_DOORS   = 4,
    parameter int N_PLAYERS = 2,
    parameter int ROM_AW    = 16
);
    logic [N_DOORS-1:0]     door_open_mask;
    logic [2*N_PLAYERS-1:0] player_pos;
    logic [2*N_PLAYERS-1:0] lives;
    logic                   resume;
    logic                   time_up;
    logic [ROM_AW-1:0]      rom_addr;
    logic [3:0]             rom_data;
    logic [3:0]             color_idx;
    logic                   hsync;
    logic                   vsync;
    logic                   video_on;
    logic                   frame_start;

    // Renderer side.
    modport master (
        input  door_open_mask, player_pos, lives, resume, time_up, rom_data,
        output rom_addr, color_idx, hsync, vsync, video_on, frame_start
    );

    // Game logic / ROM / display side.
    modport slave (
        output door_open_mask, player_pos, lives, resume, time_up, rom_data,
        input  rom_addr, color_idx, hsync, vsync, video_on, frame_start
    );
endinterface

// File: rtl/scene_renderer.sv
// 800x525 raster generator and scene composer (lives row, door row, player
// sprites) with a 3-stage pipeline around one synchronous sprite ROM.
module scene_renderer #(
    parameter int         N_DOORS      = 4,
    parameter int         N_PLAYERS    = 2,
    parameter int         MAX_LIVES    = 3,
    parameter int         DOOR_W       = 112,
    parameter int         DOOR_H       = 156,
    parameter int         HEART_W      = 22,
    parameter int         HEART_H      = 20,
    parameter int         PLAYER_W     = 24,
    parameter int         PLAYER_H     = 30,
    parameter int         SCENE_X      = 240,
    parameter int         HEART_Y      = 100,
    parameter int         DOOR_Y       = 162,
    parameter int         PLAYER_Y     = 320,
    parameter int         LIVES_PITCH  = 382,
    parameter int         PLAYER_X0    = 16,
    parameter int         PLAYER_PITCH = 56,
    parameter logic [3:0] BG_IDX       = 4'hE,
    parameter logic [3:0] TRANSP_IDX   = 4'hF
) (
    input logic               clk,
    input logic               reset,
    scene_renderer_if.master  bus
);
    localparam int DOOR_WORDS  = DOOR_W * DOOR_H;
    localparam int OPEN_BASE   = DOOR_WORDS;
    localparam int HEART_BASE  = 2 * DOOR_WORDS;
    localparam int PLAYER_BASE = HEART_BASE + HEART_W * HEART_H;
    localparam int ROM_WORDS   = PLAYER_BASE + N_PLAYERS * PLAYER_W * PLAYER_H;
    localparam int ROM_AW      = $clog2(ROM_WORDS);
    localparam logic [1:0] LIVES_CAP = (MAX_LIVES > 3) ? 2'd3 : 2'(MAX_LIVES);

    logic [9:0] x_q, y_q, x_d, y_d;
    logic       frame_edge;
    int         xi, yi;

    logic [N_DOORS-1:0]   mask_q;
    logic                 open_q;
    logic [1:0]           lives_q [N_PLAYERS];
    logic [1:0]           pos_q   [N_PLAYERS];
    logic [N_PLAYERS-1:0] vis_q;

    logic       hit_d, act_d;
    int         addr_d;
    logic       hit1_q, act1_q, hs1_q, vs1_q;
    logic       hit2_q, act2_q, hs2_q, vs2_q;
    logic [3:0] color_d;

    function automatic logic in_box(int px, int py, int x0, int y0, int w, int h);
        return (px >= x0) && (px < x0 + w) && (py >= y0) && (py < y0 + h);
    endfunction

    assign xi         = int'(x_q);
    assign yi         = int'(y_q);
    assign frame_edge = (x_q == 10'd0) && (y_q == 10'd0);
    // Gated with reset so the pulse stays low while reset is held.
    assign bus.frame_start = reset & frame_edge;

    // Raster counter next state: x wraps at 800, y steps on x wrap and wraps at 525.
    always_comb begin
        x_d = x_q + 10'd1;
        y_d = y_q;
        if (x_q == 10'd799) begin
            x_d = 10'd0;
            y_d = (y_q == 10'd524) ? 10'd0 : y_q + 10'd1;
        end
    end

    // Raster counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q <= 10'd0;
            y_q <= 10'd0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // Shadow game state, loaded once per frame so the picture never tears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
            open_q <= 1'b0;
            vis_q  <= '0;
            for (int p = 0; p < N_PLAYERS; p++) begin
                lives_q[p] <= 2'd0;
                pos_q[p]   <= 2'd0;
            end
        end else if (frame_edge) begin
            mask_q <= bus.door_open_mask;
            open_q <= bus.time_up & ~bus.resume;
            for (int p = 0; p < N_PLAYERS; p++) begin
                lives_q[p] <= (bus.lives[2*p +: 2] > LIVES_CAP) ? LIVES_CAP : bus.lives[2*p +: 2];
                pos_q[p]   <= bus.player_pos[2*p +: 2];
                vis_q[p]   <= int'(bus.player_pos[2*p +: 2]) < N_DOORS;
            end
        end
    end

    // Region hit test; evaluated lowest priority first so later matches win.
    always_comb begin
        hit_d  = 1'b0;
        addr_d = 0;
        act_d  = (xi >= 144) && (xi < 784) && (yi >= 35) && (yi < 515);
        for (int p = N_PLAYERS - 1; p >= 0; p--) begin
            for (int k = MAX_LIVES - 1; k >= 0; k--) begin
                if (k < int'(lives_q[p]) && in_box(xi, yi,
                        SCENE_X + p * LIVES_PITCH + k * HEART_W, HEART_Y, HEART_W, HEART_H)) begin
                    hit_d  = 1'b1;
                    addr_d = HEART_BASE + (yi - HEART_Y) * HEART_W
                           + (xi - (SCENE_X + p * LIVES_PITCH + k * HEART_W));
                end
            end
        end
        for (int d = N_DOORS - 1; d >= 0; d--) begin
            if (in_box(xi, yi, SCENE_X + d * DOOR_W, DOOR_Y, DOOR_W, DOOR_H)) begin
                hit_d  = 1'b1;
                addr_d = ((mask_q[d] && open_q) ? OPEN_BASE : 0)
                       + (yi - DOOR_Y) * DOOR_W + (xi - (SCENE_X + d * DOOR_W));
            end
        end
        for (int p = N_PLAYERS - 1; p >= 0; p--) begin
            if (vis_q[p] && in_box(xi, yi,
                    SCENE_X + int'(pos_q[p]) * DOOR_W + PLAYER_X0 + p * PLAYER_PITCH,
                    PLAYER_Y, PLAYER_W, PLAYER_H)) begin
                hit_d  = 1'b1;
                addr_d = PLAYER_BASE + p * PLAYER_W * PLAYER_H
                       + (yi - PLAYER_Y) * PLAYER_W
                       + (xi - (SCENE_X + int'(pos_q[p]) * DOOR_W + PLAYER_X0 + p * PLAYER_PITCH));
            end
        end
    end

    // S1/S2: ROM address (held when nothing is hit) and delayed control flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rom_addr <= '0;
            hit1_q <= 1'b0;
            act1_q <= 1'b0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            hit2_q <= 1'b0;
            act2_q <= 1'b0;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
        end else begin
            if (hit_d) begin
                bus.rom_addr <= ROM_AW'(addr_d);
            end
            hit1_q <= hit_d;
            act1_q <= act_d;
            hs1_q  <= (x_q >= 10'd96);
            vs1_q  <= (y_q >= 10'd2);
            hit2_q <= hit1_q;
            act2_q <= act1_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
        end
    end

    // S3 colour select: blank, background, transparent-to-background, or sprite.
    always_comb begin
        color_d = 4'h0;
        if (act2_q) begin
            color_d = (hit2_q && bus.rom_data != TRANSP_IDX) ? bus.rom_data : BG_IDX;
        end
    end

    // S3 output registers, all aligned 3 clocks after the counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.color_idx <= 4'h0;
            bus.hsync     <= 1'b1;
            bus.vsync     <= 1'b1;
            bus.video_on  <= 1'b0;
        end else begin
            bus.color_idx <= color_d;
            bus.hsync     <= hs2_q;
            bus.vsync     <= vs2_q;
            bus.video_on  <= act2_q;
        end
    end
endmodule
